// File: rtl/left_byte_framer.sv
// ---------------------------------------------------------------------------
// left_byte_framer
//
// Sits behind an 8-bit serial-in/parallel-out left shift register. While
// hunting it watches the register's parallel output for SYNC_WORD. Once
// locked, every 8th shifted value is captured as a data byte and pushed
// into a small show-ahead FIFO. After FRAME_LEN bytes the framer returns
// to hunting.
//
// Optional feature (macro SYNC_INV_EN):
//   When defined, hunting also accepts ~SYNC_WORD. A frame locked on the
//   inverted word has every captured byte inverted before it is pushed.
//   When undefined, no inversion state exists.
//
// Parameters:
//   SYNC_WORD  pattern that starts a frame (MSB = oldest shifted bit)
//   FRAME_LEN  data bytes per frame, 1..255
//   DEPTH      FIFO entries, power of 2, >= 2
//
// Ports:
//   clk         rising-edge clock
//   clr         asynchronous active-high reset
//   sh_en       shift_q holds a newly shifted value this cycle
//   shift_q     parallel output of the shift register
//   byte_out    FIFO head data, valid when byte_valid
//   byte_valid  FIFO not empty
//   byte_ready  consumer accepts head when byte_valid & byte_ready
//   locked      framer is in LOCK
//   ovf         sticky: a byte was dropped because the FIFO was full
//   fill        current FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module left_byte_framer #(
    parameter logic [7:0]  SYNC_WORD = 8'hA5,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     sh_en,
    input  logic [7:0]               shift_q,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     locked,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

    // Framing state
    logic [0:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic       sync_hit;
    logic       push;
    logic [7:0] push_data;

`ifdef SYNC_INV_EN
    logic       inv_q, inv_d;
    logic       inv_hit;
`endif

    // FIFO state
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [FW-1:0] fill_q, fill_d;
    logic [7:0]    head_q, head_d;
    logic          valid_q, valid_d;
    logic          ovf_q;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;

    // Sync detection and the byte that would be pushed this cycle
`ifdef SYNC_INV_EN
    assign sync_hit  = (shift_q == SYNC_WORD) || (shift_q == ~SYNC_WORD);
    assign inv_hit   = (shift_q != SYNC_WORD);
    assign push_data = inv_q ? ~shift_q : shift_q;
`else
    assign sync_hit  = (shift_q == SYNC_WORD);
    assign push_data = shift_q;
`endif

    // Framing FSM next-state logic; sh_en=0 holds everything
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        push       = 1'b0;
`ifdef SYNC_INV_EN
        inv_d      = inv_q;
`endif
        case (state_q)
            HUNT: begin
                if (sh_en && sync_hit) begin
                    state_d    = LOCK;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 8'd0;
`ifdef SYNC_INV_EN
                    inv_d      = inv_hit;
`endif
                end
            end
            LOCK: begin
                if (sh_en) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    // Eighth shift since lock / last capture completes a byte
                    if (bit_cnt_q == 3'd7) begin
                        push       = 1'b1;
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_d = HUNT;
`ifdef SYNC_INV_EN
                            inv_d   = 1'b0;
`endif
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // FIFO control: a full FIFO still accepts a push when the head pops
    always_comb begin
        pop    = valid_q & byte_ready;
        full   = (fill_q == FW'(DEPTH));
        wr_en  = push & (~full | pop);
        drop   = push & full & ~pop;

        fill_d = fill_q;
        if (wr_en && !pop) begin
            fill_d = fill_q + FW'(1);
        end else if (!wr_en && pop) begin
            fill_d = fill_q - FW'(1);
        end

        // Head register: refill from the next slot on pop, or take the
        // incoming byte directly when it becomes the only entry
        head_d = head_q;
        if (pop) begin
            if (fill_q >= FW'(2)) begin
                head_d = mem[rd_ptr_q + AW'(1)];
            end else if (wr_en) begin
                head_d = push_data;
            end
        end else if (wr_en && (fill_q == '0)) begin
            head_d = push_data;
        end

        valid_d = (fill_d != '0);
    end

    // Framing registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= HUNT;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

`ifdef SYNC_INV_EN
    // Inversion flag for the current frame
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end
`endif

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            head_q   <= 8'h00;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            fill_q  <= fill_d;
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end

    assign byte_out   = head_q;
    assign byte_valid = valid_q;
    assign locked     = (state_q == LOCK);
    assign ovf        = ovf_q;
    assign fill       = fill_q;

endmodule

// File: tb/tb_left_byte_framer.sv
// ---------------------------------------------------------------------------
// tb_left_byte_framer
//
// Randomised and directed stimulus against a behavioural model of the
// framer. The driver computes the expected effect of each clock edge and
// queues accepted bytes; a negedge monitor pops the queue on every
// handshake and compares the delivered byte. Status outputs are compared
// against the model each cycle.
// ---------------------------------------------------------------------------
module tb_left_byte_framer;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         FL   = 4;
    localparam int         D    = 4;
    localparam int         FW   = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          clr;
    logic          sh_en;
    logic [7:0]    shift_q;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic          locked;
    logic          ovf;
    logic [FW-1:0] fill;

    always #5 clk = ~clk;

    left_byte_framer #(
        .SYNC_WORD (SYNC),
        .FRAME_LEN (FL),
        .DEPTH     (D)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .sh_en      (sh_en),
        .shift_q    (shift_q),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .locked     (locked),
        .ovf        (ovf),
        .fill       (fill)
    );

    int tests = 0;
    int fails = 0;

    // Expected delivery order of accepted bytes
    logic [7:0] sb [$];

    // Behavioural model
    bit m_locked;
    int m_shifts;
    int m_bytes;
    bit m_inv;
    int m_fill;
    bit m_ovf;
    bit m_out_zero;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked   = 1'b0;
        m_shifts   = 0;
        m_bytes    = 0;
        m_inv      = 1'b0;
        m_fill     = 0;
        m_ovf      = 1'b0;
        m_out_zero = 1'b1;
        sb.delete();
    endtask

    task automatic check_outputs();
        chk("locked", int'(locked), int'(m_locked));
        chk("fill", int'(fill), m_fill);
        chk("byte_valid", int'(byte_valid), int'(m_fill > 0));
        chk("ovf", int'(ovf), int'(m_ovf));
        if (m_fill > 0 && sb.size() > 0) begin
            chk("head", int'(byte_out), int'(sb[0]));
        end else if (m_out_zero) begin
            chk("byte_out_zero", int'(byte_out), 0);
        end
    endtask

    // Called just after a rising edge: drive inputs, predict the next edge
    task automatic step(input bit sh, input logic [7:0] q, input bit rdy);
        bit         pop;
        bit         push;
        logic [7:0] data;
        sh_en      = sh;
        shift_q    = q;
        byte_ready = rdy;
        pop  = (m_fill > 0) && rdy;
        push = 1'b0;
        data = 8'h00;
        if (sh) begin
            if (!m_locked) begin
                if (q == SYNC) begin
                    m_locked = 1'b1; m_shifts = 0; m_bytes = 0; m_inv = 1'b0;
                end
`ifdef SYNC_INV_EN
                else if (q == ~SYNC) begin
                    m_locked = 1'b1; m_shifts = 0; m_bytes = 0; m_inv = 1'b1;
                end
`endif
            end else begin
                m_shifts++;
                if (m_shifts % 8 == 0) begin
                    push = 1'b1;
                    data = m_inv ? ~q : q;
                    m_bytes++;
                    if (m_bytes == FL) m_locked = 1'b0;
                end
            end
        end
        if (push) begin
            if (m_fill < D || pop) begin
                sb.push_back(data);
                m_fill++;
                m_out_zero = 1'b0;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) m_fill--;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Assert clr asynchronously, check immediately and while it is held
    task automatic do_clr(input int cycles);
        clr = 1'b1;
        model_reset();
        #1;
        check_outputs();
        for (int i = 0; i < cycles; i++) begin
            sh_en   = 1'($urandom);
            shift_q = SYNC;
            @(posedge clk);
            #1;
            check_outputs();
        end
        clr   = 1'b0;
        sh_en = 1'b0;
    endtask

    // Seven filler shifts then the captured byte on the eighth
    task automatic send_byte(input logic [7:0] b, input bit rdy_pre, input bit rdy_last);
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), rdy_pre);
        step(1'b1, b, rdy_last);
    endtask

    task automatic drain();
        for (int i = 0; i < D + 2; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    // Handshake monitor: the edge following this negedge consumes the head
    always @(negedge clk) begin
        if (!clr && byte_valid && byte_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL handshake: got %0h expected no valid byte at %0t", byte_out, $time);
            end else begin
                chk("handshake", int'(byte_out), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr        = 1'b1;
        sh_en      = 1'b0;
        shift_q    = 8'h00;
        byte_ready = 1'b0;
        model_reset();
        #1;

        // Reset with sh_en toggling, then release: still hunting
        do_clr(3);
        step(1'b1, 8'h12, 1'b0);
        step(1'b0, SYNC, 1'b0);

        // Lock and first capture
        step(1'b1, SYNC, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        drain();

        // Full frame delivered in order; trailing 8'h44 must not lock
        step(1'b1, SYNC, 1'b1);
        send_byte(8'h11, 1'b1, 1'b1);
        send_byte(8'h22, 1'b1, 1'b1);
        send_byte(8'h33, 1'b1, 1'b1);
        send_byte(8'h44, 1'b1, 1'b1);
        step(1'b1, 8'h44, 1'b1);
        drain();

        // Overflow: fill the FIFO, drop one, then push+pop while full
        step(1'b1, SYNC, 1'b0);
        send_byte(8'hA1, 1'b0, 1'b0);
        send_byte(8'hA2, 1'b0, 1'b0);
        send_byte(8'hA3, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0);
        step(1'b1, SYNC, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h66, 1'b0, 1'b1);
        drain();

        // Mid-frame reset after three shifts with a byte queued
        do_clr(1);
        step(1'b1, SYNC, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        do_clr(2);
        step(1'b1, 8'h00, 1'b0);

        // Inverted sync word (locks only with the optional feature)
        step(1'b1, 8'h5A, 1'b0);
        send_byte(8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 1'b1);
        drain();
        do_clr(1);

        // Randomised traffic with occasional resets and stall bursts
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] q;
            bit         sh;
            bit         rdy;
            sh = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0) q = ($urandom_range(1) == 0) ? SYNC : ~SYNC;
            else                        q = 8'($urandom);
            rdy = ((n / 200) % 3 == 2) ? 1'b0 : ($urandom_range(2) != 0);
            if ($urandom_range(599) == 0) do_clr(1);
            else                          step(sh, q, rdy);
        end
        drain();
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
